// File: rtl/boot_spi_pkg.sv
// Purpose: shared types and constants for the boot SPI stream (transmitter and receiver side).
// Latency: n/a (package only).
// Backpressure: n/a.
package boot_spi_pkg;

  localparam int ADDR_W    = 24;
  localparam int HDR_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HDR,
    ST_DATA,
    ST_HOLD
  } state_t;

  // Header order: start address LSB first, then end address LSB first.
  function automatic logic [7:0] hdr_byte(input logic [ADDR_W-1:0] s,
                                          input logic [ADDR_W-1:0] e,
                                          input logic [2:0]        idx);
    case (idx)
      3'd0:    hdr_byte = s[7:0];
      3'd1:    hdr_byte = s[15:8];
      3'd2:    hdr_byte = s[23:16];
      3'd3:    hdr_byte = e[7:0];
      3'd4:    hdr_byte = e[15:8];
      default: hdr_byte = e[23:16];
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Purpose: shifts one byte out MSB first on sclk/mosi; sclk idles high, mosi changes on the falling edge.
// Latency: sclk falls on the load edge; a byte takes 16*SCLK_HALF cycles; ready rises in its last cycle.
// Backpressure: load is honoured only while ready; a load in the last cycle chains bytes with no gap.
// Ports: clk25/reset (sync, active high), load + tx_byte (byte to send), ready (can take a byte now),
//        bit0_strobe (first cycle of bit 0), sclk, mosi.
module spi_byte_tx #(
  parameter int SCLK_HALF = 2
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       ready,
  output logic       bit0_strobe,
  output logic       sclk,
  output logic       mosi
);

  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  logic       active;
  logic       phase_hi;
  logic [2:0] bit_cnt;
  logic [7:0] half_cnt;
  logic [6:0] shreg;   // bits still to send after the one on mosi

  // Ready during the final high half so the next byte starts on the same edge.
  always_comb begin
    ready = !active || (phase_hi && (half_cnt == HALF_LAST) && (bit_cnt == 3'd7));
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      active      <= 1'b0;
      phase_hi    <= 1'b0;
      bit_cnt     <= 3'd0;
      half_cnt    <= 8'd0;
      shreg       <= 7'd0;
      bit0_strobe <= 1'b0;
      sclk        <= 1'b1;
      mosi        <= 1'b1;
    end else begin
      bit0_strobe <= 1'b0;
      if (load && ready) begin
        active      <= 1'b1;
        phase_hi    <= 1'b0;
        bit_cnt     <= 3'd0;
        half_cnt    <= 8'd0;
        shreg       <= tx_byte[6:0];
        bit0_strobe <= 1'b1;
        sclk        <= 1'b0;
        mosi        <= tx_byte[7];
      end else if (active) begin
        if (half_cnt == HALF_LAST) begin
          half_cnt <= 8'd0;
          if (!phase_hi) begin
            phase_hi <= 1'b1;
            sclk     <= 1'b1;
          end else if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            mosi   <= 1'b1;
          end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            phase_hi <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= shreg[6];
            shreg    <= {shreg[5:0], 1'b0};
          end
        end else begin
          half_cnt <= half_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/boot_spi_tx.sv
// Purpose: SPI master sending the boot stream: start addr, end addr (3 bytes each, LSB first), then image bytes.
// Latency: SS falls on the edge after start; first SCLK fall SS_SETUP cycles later; done SS_HOLD after last rise.
// Backpressure: none; start is ignored while busy, rejected with error when end_addr < start_addr.
// Ports: clk25/reset (sync, active high), start/start_addr/end_addr (request), busy/done/error (status),
//        mem_addr/mem_rd/mem_data (image read port, data one cycle after mem_rd), arm_ss/arm_sclk/arm_mosi.
module boot_spi_tx
  import boot_spi_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int SS_SETUP  = 25,
  parameter int SS_HOLD   = 25
) (
  input  logic              clk25,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              arm_ss,
  output logic              arm_sclk,
  output logic              arm_mosi
);

  localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
  localparam logic [15:0] HOLD_END   = 16'(SS_HOLD);
  // HOLD is entered SCLK_HALF cycles after the last rise; the counter tracks cycles since that rise.
  localparam logic [15:0] HOLD_INIT  = 16'(SCLK_HALF + 1);
  localparam logic [2:0]  HDR_LAST   = 3'(HDR_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   data_left;   // data bytes not yet loaded; 25 bits covers a full 2^24 image
  logic [2:0]        hdr_idx;
  logic [15:0]       cnt;
  logic [7:0]        next_byte;
  logic              cap_pend;

  logic       load;
  logic [7:0] load_byte;
  logic       ready;
  logic       bit0_strobe;

  always_comb begin
    load      = 1'b0;
    load_byte = next_byte;
    case (state)
      ST_SETUP: begin
        load      = (cnt == SETUP_LAST);
        load_byte = hdr_byte(start_q, end_q, 3'd0);
      end
      ST_HDR: begin
        load      = ready;
        load_byte = hdr_byte(start_q, end_q, hdr_idx);
      end
      ST_DATA: begin
        load = ready && (data_left != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      arm_ss    <= 1'b1;
      start_q   <= '0;
      end_q     <= '0;
      rd_addr   <= '0;
      data_left <= '0;
      hdr_idx   <= 3'd0;
      cnt       <= 16'd0;
      next_byte <= 8'd0;
      cap_pend  <= 1'b0;
    end else begin
      done     <= 1'b0;
      error    <= 1'b0;
      mem_rd   <= 1'b0;
      // The read strobe coincides with bit 0 of the byte that triggered it; data lands a cycle later.
      cap_pend <= bit0_strobe && mem_rd;
      if (cap_pend) next_byte <= mem_data;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (end_addr < start_addr) begin
              error <= 1'b1;
            end else begin
              start_q   <= start_addr;
              end_q     <= end_addr;
              rd_addr   <= start_addr;
              data_left <= {1'b0, end_addr} - {1'b0, start_addr} + 25'd1;
              busy      <= 1'b1;
              arm_ss    <= 1'b0;
              cnt       <= 16'd0;
              state     <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (load) begin
            hdr_idx <= 3'd1;
            state   <= ST_HDR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_HDR: begin
          if (load) begin
            hdr_idx <= hdr_idx + 3'd1;
            if (hdr_idx == HDR_LAST) begin
              // At least one data byte always follows the header.
              mem_rd   <= 1'b1;
              mem_addr <= rd_addr;
              rd_addr  <= rd_addr + 1'b1;
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (load) begin
            data_left <= data_left - 25'd1;
            if (data_left > 25'd1) begin
              mem_rd   <= 1'b1;
              mem_addr <= rd_addr;
              rd_addr  <= rd_addr + 1'b1;
            end
          end else if (ready) begin
            cnt   <= HOLD_INIT;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt >= HOLD_END) begin
            arm_ss <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_byte_tx #(
    .SCLK_HALF(SCLK_HALF)
  ) u_byte (
    .clk25      (clk25),
    .reset      (reset),
    .load       (load),
    .tx_byte    (load_byte),
    .ready      (ready),
    .bit0_strobe(bit0_strobe),
    .sclk       (arm_sclk),
    .mosi       (arm_mosi)
  );

endmodule
